uart_cmd_engine: RTL and testbench
==================================

Name: uart_cmd_engine

Overview:
Parametrised UART command/response engine, the successor to the fixed 12-channel RS232 command path in the AI channel controller. It parses framed commands from a byte-level UART RX interface and validates a checksum. It serves AD-channel snapshot reads, calibration-channel selection and EEPROM read/write requests, then returns framed responses through the byte-level UART TX interface. It adds an inter-byte timeout, an EEPROM timeout, status codes and an error counter.

Parameters:
NCH, 12, channel count, 1..127
DW, 16, AD sample width; fixed at 16 in this generation
RX_TMO, 125000, max idle cycles between RX bytes of one frame
E2P_TMO, 1250000, max cycles waiting on EEPROM busy/done/dval

Ports:
clk_sys  in  1  system clock
rst_sys  in  1  synchronous reset, active high
uart_rx_ren  in  1  RX byte-valid strobe, 1 cycle
uart_rx_rdata  in  8  RX byte
uart_tx_wen  out  1  TX byte write strobe
uart_tx_wdata  out  8  TX byte
uart_tx_rdy  in  1  TX accepts a byte
ad_rd_dval  in  NCH  per-channel sample-valid strobe
ad_rd_value  in  NCH*DW  packed samples; ch i = [i*DW +: DW]
e2p_busy  in  1  EEPROM controller busy
e2p_rd_en  out  1  EEPROM read request pulse
e2p_wr_en  out  1  EEPROM write request pulse
e2p_addr  out  16  EEPROM address
e2p_wr_value  out  128  write payload; byte0 in [127:120]
e2p_wr_done  in  1  write complete pulse
e2p_rd_dval  in  1  read data valid pulse
e2p_rd_value  in  32  read data
cal_ch_index  out  NCH  one-hot selected calibration channel
err_cnt  out  8  saturating frame-error count

Behaviour:
- Clock and reset: one clock, clk_sys. Reset rst_sys is synchronous and active high. On reset, all outputs are 0, state is RX_HDR, and all snapshots are 0.
- Snapshots: on ad_rd_dval[i], snap[i] <= sample i. Reads return snap, never the live input.
- RX frame format: A5, CMD, ADH, ADL, [16 payload bytes for CMD 10 only], CHK.
- CHK is the XOR of every byte after A5, up to but not including CHK.
- RX states: RX_HDR, RX_CMD, RX_ADH, RX_ADL, RX_PLD, RX_CHK, then EXEC, E2P_WAIT, TX.
  - In RX_HDR, any byte other than A5 is discarded silently.
- RX timeout: the timeout counter clears on every byte. A gap greater than RX_TMO in any RX state after RX_HDR:
  - drops the frame and returns to RX_HDR;
  - increments err_cnt;
  - sends no response.
- uart_rx_ren during EXEC, E2P_WAIT or TX: byte is ignored.
- Commands:
  - 01: read snap[ADL]; LEN=2, high byte first.
  - 02: read all channels; LEN=2*NCH, ch0 first.
  - 10: EEPROM write of the 16-byte payload to {ADH,ADL}; LEN=0.
  - 11: EEPROM read of {ADH,ADL}; LEN=4, MSB first.
  - 20: cal_ch_index <= one-hot(ADL); LEN=0.
- Status codes: 00 ok, 01 checksum error, 02 unknown CMD or ADL>=NCH (cmds 01/20), 03 EEPROM timeout.
  - On any non-zero status, LEN=0.
  - Status 01 and 02 increment err_cnt; err_cnt saturates at FF.
  - Checksum is checked before the command; cal_ch_index is unchanged on error.
- EEPROM access:
  - EXEC waits while e2p_busy is high.
  - Then it issues a 1-cycle e2p_wr_en or e2p_rd_en, with e2p_addr and e2p_wr_value valid in that cycle and held until the response completes.
  - E2P_WAIT ends on e2p_wr_done (cmd 10) or e2p_rd_dval (cmd 11); rd_value is latched then.
  - The E2P_TMO counter runs from EXEC entry; on expiry, status is 03.
- Response frame: 5A, CMD, STATUS, LEN, data[LEN], CHK; CHK is the XOR of CMD through the last data byte.
- TX handshake:
  - One byte per cycle in which uart_tx_rdy is high, with uart_tx_wen high for exactly that cycle.
  - If uart_tx_rdy is low, hold uart_tx_wdata and keep uart_tx_wen low.
  - After CHK is sent, return to RX_HDR.
- Simultaneous events: an ad_rd_dval during a cmd 02 response may update channels not yet sent; no coherency across channels.
- Reset mid-operation: any state returns to RX_HDR on the next edge with uart_tx_wen=0; a pending EEPROM request is abandoned.

Optional Feature:
UART_CMD_CRC8_EN
- Defined: CHK in both directions is CRC-8 (poly 0x07, init 0x00, MSB-first) over the same byte span.
- Undefined: CHK is XOR. Frame layout and status codes are unchanged.

Test Plan:
- snap3=0x1234, RX A5 01 00 03 02 -> TX 5A 01 00 02 12 34 25.
- RX A5 01 00 03 FF -> TX 5A 01 01 00 00; err_cnt=1.
- RX A5 01 00 0C 0D (NCH=12) -> TX 5A 01 02 00 03; err_cnt=1. RX A5 20 00 05 25 -> cal_ch_index=0x020; TX 5A 20 00 00 20.
- RX A5 10 00 40, bytes 00..0F, then 50:
  - expect e2p_wr_en for 1 cycle, e2p_addr=0x0040, e2p_wr_value=0x000102..0F;
  - with e2p_wr_done after 10 cycles -> TX 5A 10 00 00 10;
  - with no done -> after E2P_TMO, TX 5A 10 03 00 13.
- RX A5 01, then idle RX_TMO+1 cycles -> no TX, err_cnt+1; next valid frame answered normally. uart_tx_rdy toggling 1/0 during a response -> byte stream unchanged.
- Assert rst_sys mid-TX of a cmd 02 response -> uart_tx_wen=0 next cycle, all outputs 0; a following frame is answered normally.

Source files
------------

// File: rtl/uart_cmd_engine.sv
// uart_cmd_engine: UART command/response engine.
//
// Receives framed commands from a byte-level UART RX interface and checks their checksum.
// It serves AD snapshot reads, calibration-channel selection and EEPROM read/write
// requests, then sends a framed response on the byte-level UART TX interface.
//
// Optional feature macro: UART_CMD_CRC8_EN. When defined, CHK in both directions is
// CRC-8 (poly 0x07, init 0x00, MSB-first). When undefined, CHK is a plain XOR.
//
// Ports:
//   clk_sys, rst_sys          system clock, synchronous active-high reset
//   uart_rx_ren/rdata         RX byte strobe and byte
//   uart_tx_wen/wdata/rdy     TX byte strobe, byte, sink ready
//   ad_rd_dval/value          per-channel sample strobes, packed samples (ch i at [i*DW +: DW])
//   e2p_*                     EEPROM request/response handshake
//   cal_ch_index              one-hot calibration channel
//   err_cnt                   saturating frame-error count
module uart_cmd_engine #(
    parameter int unsigned NCH     = 12,
    parameter int unsigned DW      = 16,
    parameter int unsigned RX_TMO  = 125000,
    parameter int unsigned E2P_TMO = 1250000
) (
    input  logic              clk_sys,
    input  logic              rst_sys,
    input  logic              uart_rx_ren,
    input  logic [7:0]        uart_rx_rdata,
    output logic              uart_tx_wen,
    output logic [7:0]        uart_tx_wdata,
    input  logic              uart_tx_rdy,
    input  logic [NCH-1:0]    ad_rd_dval,
    input  logic [NCH*DW-1:0] ad_rd_value,
    input  logic              e2p_busy,
    output logic              e2p_rd_en,
    output logic              e2p_wr_en,
    output logic [15:0]       e2p_addr,
    output logic [127:0]      e2p_wr_value,
    input  logic              e2p_wr_done,
    input  logic              e2p_rd_dval,
    input  logic [31:0]       e2p_rd_value,
    output logic [NCH-1:0]    cal_ch_index,
    output logic [7:0]        err_cnt
);

    typedef enum logic [3:0] {
        StRxHdr, StRxCmd, StRxAdh, StRxAdl, StRxPld, StRxChk, StExec, StE2pWait, StTx
    } state_e;

    localparam logic [7:0] CmdRdOne = 8'h01;
    localparam logic [7:0] CmdRdAll = 8'h02;
    localparam logic [7:0] CmdE2pWr = 8'h10;
    localparam logic [7:0] CmdE2pRd = 8'h11;
    localparam logic [7:0] CmdCal   = 8'h20;

    function automatic logic [7:0] chk_next(input logic [7:0] acc, input logic [7:0] b);
`ifdef UART_CMD_CRC8_EN
        logic [7:0] c;
        c = acc ^ b;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
`else
        return acc ^ b;
`endif
    endfunction

    state_e              state_q;
    logic [7:0]          cmd_q, adh_q, adl_q, rx_chk_q;
    logic                chk_ok_q;
    logic [127:0]        pld_q;
    logic [3:0]          pld_cnt_q;
    logic [31:0]         rx_tmo_q, e2p_tmo_q;
    logic [7:0]          status_q, len_q;
    logic [8:0]          tx_idx_q;
    logic [7:0]          tx_chk_q;
    logic [31:0]         rd_value_q;
    logic [NCH*DW-1:0]   snap_q;

    logic                adl_ok, rx_active, rx_to, exec_err, err_bump;
    logic [NCH-1:0]      adl_onehot;
    logic [8:0]          nidx, k, last_idx;
    logic [31:0]         ch;
    logic [DW-1:0]       sample;
    logic [7:0]          rd_byte, tx_chk_nxt, tx_byte_nxt;

    // The TX sink consumes the held byte in any Tx cycle where it is ready.
    assign uart_tx_wen = (state_q == StTx) && uart_tx_rdy;

    assign adl_ok    = 32'(adl_q) < NCH;
    assign rx_active = state_q inside {StRxCmd, StRxAdh, StRxAdl, StRxPld, StRxChk};
    assign rx_to     = rx_active && !uart_rx_ren && (rx_tmo_q >= RX_TMO);
    assign exec_err  = (state_q == StExec) &&
                       (!chk_ok_q ||
                        (((cmd_q == CmdRdOne) || (cmd_q == CmdCal)) && !adl_ok) ||
                        !(cmd_q inside {CmdRdOne, CmdRdAll, CmdE2pWr, CmdE2pRd, CmdCal}));
    assign err_bump  = rx_to || exec_err;

    always_comb begin
        for (int i = 0; i < int'(NCH); i++) begin
            adl_onehot[i] = (32'(adl_q) == 32'(i));
        end
    end

    // Next TX byte, computed from the byte currently held on uart_tx_wdata.
    always_comb begin
        nidx       = tx_idx_q + 9'd1;
        k          = nidx - 9'd4;
        last_idx   = 9'd4 + {1'b0, len_q};
        // Byte 0 (5A) is outside the checksum span.
        tx_chk_nxt = (tx_idx_q == 9'd0) ? 8'h00 : chk_next(tx_chk_q, uart_tx_wdata);
        ch         = (cmd_q == CmdRdOne) ? 32'(adl_q) : 32'(k[8:1]);
        if (ch >= NCH) begin
            ch = 32'd0;
        end
        sample = snap_q[ch*DW +: DW];
        case (k[1:0])
            2'd0:    rd_byte = rd_value_q[31:24];
            2'd1:    rd_byte = rd_value_q[23:16];
            2'd2:    rd_byte = rd_value_q[15:8];
            default: rd_byte = rd_value_q[7:0];
        endcase
        if (nidx == 9'd1) begin
            tx_byte_nxt = cmd_q;
        end else if (nidx == 9'd2) begin
            tx_byte_nxt = status_q;
        end else if (nidx == 9'd3) begin
            tx_byte_nxt = len_q;
        end else if (nidx == last_idx) begin
            tx_byte_nxt = tx_chk_nxt;
        end else if (cmd_q == CmdE2pRd) begin
            tx_byte_nxt = rd_byte;
        end else begin
            tx_byte_nxt = k[0] ? sample[7:0] : sample[DW-1 -: 8];
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            state_q       <= StRxHdr;
            cmd_q         <= 8'h00;
            adh_q         <= 8'h00;
            adl_q         <= 8'h00;
            rx_chk_q      <= 8'h00;
            chk_ok_q      <= 1'b0;
            pld_q         <= '0;
            pld_cnt_q     <= 4'd0;
            rx_tmo_q      <= 32'd0;
            e2p_tmo_q     <= 32'd0;
            status_q      <= 8'h00;
            len_q         <= 8'h00;
            tx_idx_q      <= 9'd0;
            tx_chk_q      <= 8'h00;
            rd_value_q    <= 32'd0;
            snap_q        <= '0;
            uart_tx_wdata <= 8'h00;
            e2p_rd_en     <= 1'b0;
            e2p_wr_en     <= 1'b0;
            e2p_addr      <= 16'h0000;
            e2p_wr_value  <= '0;
            cal_ch_index  <= '0;
            err_cnt       <= 8'h00;
        end else begin
            e2p_rd_en <= 1'b0;
            e2p_wr_en <= 1'b0;
            for (int i = 0; i < int'(NCH); i++) begin
                if (ad_rd_dval[i]) begin
                    snap_q[i*DW +: DW] <= ad_rd_value[i*DW +: DW];
                end
            end
            if (err_bump && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end

            unique case (state_q)
                StRxHdr: begin
                    rx_tmo_q <= 32'd0;
                    if (uart_rx_ren && (uart_rx_rdata == 8'hA5)) begin
                        rx_chk_q <= 8'h00;
                        state_q  <= StRxCmd;
                    end
                end
                StRxCmd, StRxAdh, StRxAdl, StRxPld, StRxChk: begin
                    if (uart_rx_ren) begin
                        rx_tmo_q <= 32'd0;
                        rx_chk_q <= chk_next(rx_chk_q, uart_rx_rdata);
                        case (state_q)
                            StRxCmd: begin
                                cmd_q   <= uart_rx_rdata;
                                state_q <= StRxAdh;
                            end
                            StRxAdh: begin
                                adh_q   <= uart_rx_rdata;
                                state_q <= StRxAdl;
                            end
                            StRxAdl: begin
                                adl_q     <= uart_rx_rdata;
                                pld_cnt_q <= 4'd0;
                                state_q   <= (cmd_q == CmdE2pWr) ? StRxPld : StRxChk;
                            end
                            StRxPld: begin
                                // First payload byte ends up in the top byte.
                                pld_q     <= {pld_q[119:0], uart_rx_rdata};
                                pld_cnt_q <= pld_cnt_q + 4'd1;
                                if (pld_cnt_q == 4'd15) begin
                                    state_q <= StRxChk;
                                end
                            end
                            default: begin
                                chk_ok_q  <= (uart_rx_rdata == rx_chk_q);
                                e2p_tmo_q <= 32'd0;
                                state_q   <= StExec;
                            end
                        endcase
                    end else if (rx_tmo_q >= RX_TMO) begin
                        state_q <= StRxHdr;
                    end else begin
                        rx_tmo_q <= rx_tmo_q + 32'd1;
                    end
                end
                StExec: begin
                    uart_tx_wdata <= 8'h5A;
                    tx_idx_q      <= 9'd0;
                    tx_chk_q      <= 8'h00;
                    status_q      <= 8'h00;
                    len_q         <= 8'h00;
                    if (!chk_ok_q) begin
                        status_q <= 8'h01;
                        state_q  <= StTx;
                    end else begin
                        case (cmd_q)
                            CmdRdOne: begin
                                if (adl_ok) len_q <= 8'd2;
                                else        status_q <= 8'h02;
                                state_q <= StTx;
                            end
                            CmdRdAll: begin
                                len_q   <= 8'(2 * NCH);
                                state_q <= StTx;
                            end
                            CmdCal: begin
                                if (adl_ok) cal_ch_index <= adl_onehot;
                                else        status_q <= 8'h02;
                                state_q <= StTx;
                            end
                            CmdE2pWr, CmdE2pRd: begin
                                if (e2p_tmo_q >= E2P_TMO) begin
                                    status_q <= 8'h03;
                                    state_q  <= StTx;
                                end else begin
                                    e2p_tmo_q <= e2p_tmo_q + 32'd1;
                                    if (!e2p_busy) begin
                                        e2p_addr <= {adh_q, adl_q};
                                        if (cmd_q == CmdE2pWr) begin
                                            e2p_wr_en    <= 1'b1;
                                            e2p_wr_value <= pld_q;
                                        end else begin
                                            e2p_rd_en <= 1'b1;
                                        end
                                        state_q <= StE2pWait;
                                    end
                                end
                            end
                            default: begin
                                status_q <= 8'h02;
                                state_q  <= StTx;
                            end
                        endcase
                    end
                end
                StE2pWait: begin
                    uart_tx_wdata <= 8'h5A;
                    tx_idx_q      <= 9'd0;
                    tx_chk_q      <= 8'h00;
                    if ((cmd_q == CmdE2pWr) && e2p_wr_done) begin
                        status_q <= 8'h00;
                        len_q    <= 8'd0;
                        state_q  <= StTx;
                    end else if ((cmd_q == CmdE2pRd) && e2p_rd_dval) begin
                        rd_value_q <= e2p_rd_value;
                        status_q   <= 8'h00;
                        len_q      <= 8'd4;
                        state_q    <= StTx;
                    end else if (e2p_tmo_q >= E2P_TMO) begin
                        status_q <= 8'h03;
                        len_q    <= 8'd0;
                        state_q  <= StTx;
                    end else begin
                        e2p_tmo_q <= e2p_tmo_q + 32'd1;
                    end
                end
                StTx: begin
                    if (uart_tx_rdy) begin
                        if (tx_idx_q == last_idx) begin
                            state_q <= StRxHdr;
                        end else begin
                            tx_idx_q      <= nidx;
                            tx_chk_q      <= tx_chk_nxt;
                            uart_tx_wdata <= tx_byte_nxt;
                        end
                    end
                end
                default: state_q <= StRxHdr;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_engine.sv
// Directed bench for uart_cmd_engine with a TX byte scoreboard.
module tb_uart_cmd_engine;

    localparam int NCH     = 12;
    localparam int RX_TMO  = 40;
    localparam int E2P_TMO = 100;

    logic              clk_sys = 1'b0;
    logic              rst_sys = 1'b1;
    logic              uart_rx_ren = 1'b0;
    logic [7:0]        uart_rx_rdata = 8'h00;
    logic              uart_tx_wen;
    logic [7:0]        uart_tx_wdata;
    logic              uart_tx_rdy = 1'b1;
    logic [NCH-1:0]    ad_rd_dval = '0;
    logic [NCH*16-1:0] ad_rd_value = '0;
    logic              e2p_busy = 1'b0;
    logic              e2p_rd_en, e2p_wr_en;
    logic [15:0]       e2p_addr;
    logic [127:0]      e2p_wr_value;
    logic              e2p_wr_done = 1'b0;
    logic              e2p_rd_dval = 1'b0;
    logic [31:0]       e2p_rd_value = 32'h0;
    logic [NCH-1:0]    cal_ch_index;
    logic [7:0]        err_cnt;

    uart_cmd_engine #(.NCH(NCH), .DW(16), .RX_TMO(RX_TMO), .E2P_TMO(E2P_TMO)) dut (
        .clk_sys(clk_sys), .rst_sys(rst_sys),
        .uart_rx_ren(uart_rx_ren), .uart_rx_rdata(uart_rx_rdata),
        .uart_tx_wen(uart_tx_wen), .uart_tx_wdata(uart_tx_wdata), .uart_tx_rdy(uart_tx_rdy),
        .ad_rd_dval(ad_rd_dval), .ad_rd_value(ad_rd_value),
        .e2p_busy(e2p_busy), .e2p_rd_en(e2p_rd_en), .e2p_wr_en(e2p_wr_en),
        .e2p_addr(e2p_addr), .e2p_wr_value(e2p_wr_value), .e2p_wr_done(e2p_wr_done),
        .e2p_rd_dval(e2p_rd_dval), .e2p_rd_value(e2p_rd_value),
        .cal_ch_index(cal_ch_index), .err_cnt(err_cnt)
    );

    always #5 clk_sys = ~clk_sys;

    int           n_assert = 0;
    int           n_fail = 0;
    logic [7:0]   exp_q[$];
    logic [7:0]   d_q[$];
    bit           mon_en = 1'b1;
    int           wr_pulses = 0;
    int           rd_pulses = 0;
    logic [15:0]  cap_addr = 16'h0;
    logic [127:0] cap_val = '0;
    logic [15:0]  snap_m[NCH];
    logic [7:0]   err_m = 8'h00;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every accepted TX byte must be the next expected one.
    always @(negedge clk_sys) begin
        if (mon_en && uart_tx_wen) begin
            if (exp_q.size() == 0) begin
                n_assert++;
                n_fail++;
                $error("FAIL unexpected_tx: observed %0h expected none", uart_tx_wdata);
            end else begin
                check("tx_byte", {120'd0, uart_tx_wdata}, {120'd0, exp_q.pop_front()});
            end
        end
    end

    always @(negedge clk_sys) begin
        if (e2p_wr_en) begin
            wr_pulses++;
            cap_addr = e2p_addr;
            cap_val  = e2p_wr_value;
        end
        if (e2p_rd_en) begin
            rd_pulses++;
            cap_addr = e2p_addr;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk_sys); #1;
        uart_rx_ren   = 1'b1;
        uart_rx_rdata = b;
        @(posedge clk_sys); #1;
        uart_rx_ren   = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] cmd, input logic [7:0] adh,
                            input logic [7:0] adl, input logic [127:0] pld);
        logic [7:0] c;
        logic [7:0] b;
        c = cmd ^ adh ^ adl;
        send_byte(8'hA5);
        send_byte(cmd);
        send_byte(adh);
        send_byte(adl);
        if (cmd == 8'h10) begin
            for (int i = 0; i < 16; i++) begin
                b = pld[127 - 8*i -: 8];
                c = c ^ b;
                send_byte(b);
            end
        end
        send_byte(c);
    endtask

    // Queue 5A CMD STATUS LEN data CHK, data taken from d_q.
    task automatic push_resp(input logic [7:0] cmd, input logic [7:0] status);
        logic [7:0] c;
        logic [7:0] len;
        len = 8'(d_q.size());
        c = cmd ^ status ^ len;
        exp_q.push_back(8'h5A);
        exp_q.push_back(cmd);
        exp_q.push_back(status);
        exp_q.push_back(len);
        foreach (d_q[i]) begin
            c = c ^ d_q[i];
            exp_q.push_back(d_q[i]);
        end
        exp_q.push_back(c);
        d_q.delete();
    endtask

    task automatic wait_resp(input bit toggle, input string tag);
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) begin
            @(posedge clk_sys); #1;
            if (toggle) uart_tx_rdy = ~uart_tx_rdy;
        end
        uart_tx_rdy = 1'b1;
        repeat (4) @(posedge clk_sys);
        #1;
        check(tag, 128'(exp_q.size()), 128'd0);
        exp_q.delete();
    endtask

    task automatic pulse_dval(input int c, input logic [15:0] v);
        @(posedge clk_sys); #1;
        ad_rd_value[c*16 +: 16] = v;
        ad_rd_dval[c] = 1'b1;
        snap_m[c] = v;
        @(posedge clk_sys); #1;
        ad_rd_dval = '0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_wen"}, 128'(uart_tx_wen), 128'd0);
        check({tag, "_wdata"}, 128'(uart_tx_wdata), 128'd0);
        check({tag, "_rd_en"}, 128'(e2p_rd_en), 128'd0);
        check({tag, "_wr_en"}, 128'(e2p_wr_en), 128'd0);
        check({tag, "_addr"}, 128'(e2p_addr), 128'd0);
        check({tag, "_wr_value"}, e2p_wr_value, 128'd0);
        check({tag, "_cal"}, 128'(cal_ch_index), 128'd0);
        check({tag, "_err_cnt"}, 128'(err_cnt), 128'd0);
    endtask

    localparam logic [127:0] Pld = 128'h000102030405060708090A0B0C0D0E0F;

    initial begin
        int seen;
        foreach (snap_m[i]) snap_m[i] = 16'h0;
        repeat (3) @(posedge clk_sys);
        #1;
        check_outputs_zero("reset");
        rst_sys = 1'b0;

        // Snapshot read of channel 3; live input changes afterwards without a strobe.
        pulse_dval(3, 16'h1234);
        ad_rd_value[3*16 +: 16] = 16'hDEAD;
        foreach (exp_q[i]) exp_q[i] = 8'h00;
        exp_q = '{8'h5A, 8'h01, 8'h00, 8'h02, 8'h12, 8'h34, 8'h25};
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h03); send_byte(8'h02);
        wait_resp(1'b0, "rd_one_done");

        // Checksum error.
        exp_q = '{8'h5A, 8'h01, 8'h01, 8'h00, 8'h00};
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h03); send_byte(8'hFF);
        wait_resp(1'b0, "bad_chk_done");
        err_m++;
        check("err_after_bad_chk", 128'(err_cnt), 128'(err_m));

        // ADL out of range for cmd 01.
        exp_q = '{8'h5A, 8'h01, 8'h02, 8'h00, 8'h03};
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h0C); send_byte(8'h0D);
        wait_resp(1'b0, "adl_range_done");
        err_m++;
        check("err_after_adl_range", 128'(err_cnt), 128'(err_m));

        // Calibration select, then an out-of-range select leaves it unchanged.
        exp_q = '{8'h5A, 8'h20, 8'h00, 8'h00, 8'h20};
        send_byte(8'hA5); send_byte(8'h20); send_byte(8'h00); send_byte(8'h05); send_byte(8'h25);
        wait_resp(1'b0, "cal_done");
        check("cal_index", 128'(cal_ch_index), 128'h020);
        push_resp(8'h20, 8'h02);
        send_cmd(8'h20, 8'h00, 8'h0C, '0);
        wait_resp(1'b0, "cal_bad_done");
        err_m++;
        check("cal_unchanged", 128'(cal_ch_index), 128'h020);
        check("err_after_cal_bad", 128'(err_cnt), 128'(err_m));

        // Read all channels with junk before the header and a toggling TX ready.
        for (int c = 0; c < NCH; c++) pulse_dval(c, 16'hA000 + 16'(c * 16'h0111));
        for (int c = 0; c < NCH; c++) begin
            d_q.push_back(snap_m[c][15:8]);
            d_q.push_back(snap_m[c][7:0]);
        end
        push_resp(8'h02, 8'h00);
        send_byte(8'h00); send_byte(8'h5A); send_byte(8'hFF);
        send_cmd(8'h02, 8'h00, 8'h00, '0);
        wait_resp(1'b1, "rd_all_done");

        // EEPROM write held off by busy, completed by wr_done.
        wr_pulses = 0;
        e2p_busy = 1'b1;
        send_cmd(8'h10, 8'h00, 8'h40, Pld);
        repeat (20) @(posedge clk_sys);
        #1;
        check("e2p_wr_while_busy", 128'(wr_pulses), 128'd0);
        e2p_busy = 1'b0;
        for (int i = 0; i < 50 && wr_pulses == 0; i++) begin
            @(posedge clk_sys); #1;
        end
        check("e2p_wr_pulse", 128'(wr_pulses), 128'd1);
        check("e2p_wr_addr", 128'(cap_addr), 128'h0040);
        check("e2p_wr_value", cap_val, Pld);
        repeat (9) @(posedge clk_sys);
        #1;
        check("e2p_wr_single", 128'(wr_pulses), 128'd1);
        check("e2p_addr_held", 128'(e2p_addr), 128'h0040);
        push_resp(8'h10, 8'h00);
        e2p_wr_done = 1'b1;
        @(posedge clk_sys); #1;
        e2p_wr_done = 1'b0;
        wait_resp(1'b0, "e2p_wr_done");

        // EEPROM write with no completion times out.
        wr_pulses = 0;
        exp_q = '{8'h5A, 8'h10, 8'h03, 8'h00, 8'h13};
        send_cmd(8'h10, 8'h00, 8'h40, Pld);
        wait_resp(1'b0, "e2p_tmo_done");
        check("e2p_tmo_pulse", 128'(wr_pulses), 128'd1);

        // EEPROM read; the source value is removed right after the strobe.
        rd_pulses = 0;
        send_cmd(8'h11, 8'h12, 8'h34, '0);
        for (int i = 0; i < 50 && rd_pulses == 0; i++) begin
            @(posedge clk_sys); #1;
        end
        check("e2p_rd_pulse", 128'(rd_pulses), 128'd1);
        check("e2p_rd_addr", 128'(cap_addr), 128'h1234);
        d_q = '{8'hCA, 8'hFE, 8'hBA, 8'hBE};
        push_resp(8'h11, 8'h00);
        repeat (5) @(posedge clk_sys);
        #1;
        e2p_rd_value = 32'hCAFEBABE;
        e2p_rd_dval  = 1'b1;
        @(posedge clk_sys); #1;
        e2p_rd_dval  = 1'b0;
        e2p_rd_value = 32'h0;
        wait_resp(1'b0, "e2p_rd_done");

        // Unknown command.
        push_resp(8'h33, 8'h02);
        send_cmd(8'h33, 8'h00, 8'h00, '0);
        wait_resp(1'b0, "unknown_done");
        err_m++;
        check("err_after_unknown", 128'(err_cnt), 128'(err_m));

        // Inter-byte gap of RX_TMO+1 idle cycles drops the frame silently.
        send_byte(8'hA5);
        send_byte(8'h01);
        repeat (RX_TMO + 1) @(posedge clk_sys);
        #1;
        err_m++;
        check("err_after_rx_tmo", 128'(err_cnt), 128'(err_m));
        repeat (20) @(posedge clk_sys);
        #1;
        check("rx_tmo_no_tx", 128'(exp_q.size()), 128'd0);

        // A gap of exactly RX_TMO idle cycles is tolerated.
        d_q = '{snap_m[3][15:8], snap_m[3][7:0]};
        push_resp(8'h01, 8'h00);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        repeat (RX_TMO - 1) @(posedge clk_sys);
        send_byte(8'h03); send_byte(8'h02);
        wait_resp(1'b0, "rx_gap_ok_done");
        check("err_after_gap_ok", 128'(err_cnt), 128'(err_m));

        // Reset in the middle of a read-all response.
        mon_en = 1'b0;
        send_cmd(8'h02, 8'h00, 8'h00, '0);
        seen = 0;
        for (int i = 0; i < 200 && seen < 3; i++) begin
            @(negedge clk_sys);
            if (uart_tx_wen) seen++;
        end
        check("mid_tx_started", 128'(seen), 128'd3);
        rst_sys = 1'b1;
        @(posedge clk_sys); #1;
        check_outputs_zero("mid_tx_reset");
        rst_sys = 1'b0;
        exp_q.delete();
        foreach (snap_m[i]) snap_m[i] = 16'h0;
        mon_en = 1'b1;
        d_q = '{8'h00, 8'h00};
        push_resp(8'h01, 8'h00);
        send_cmd(8'h01, 8'h00, 8'h03, '0);
        wait_resp(1'b0, "after_reset_done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
